// File: rtl/vlsu_txn_sequencer_pkg.sv
// Shared types and helpers for the VLSU transaction sequencer.
// Holds the bus geometry constants, the one-hot mode constants,
// request-level (glb) and segment-level (seglv) metadata records, and the
// segment-level init arithmetic used by the SEG_INIT state.
package vlsu_txn_sequencer_pkg;

  localparam int VLSU_ADDR_BITS = 32;
  localparam int VLEN_BITS      = 16;
  localparam int SLEN           = 256;
  localparam int TXN_NBS        = SLEN / 4;
  localparam int OFF_W          = $clog2(TXN_NBS);
  localparam int TXN_NBS_W      = OFF_W + 1;
  localparam int NR_LANES       = 4;

  localparam logic [3:0] MODE_INCR  = 4'b0001;
  localparam logic [3:0] MODE_STRD  = 4'b0010;
  localparam logic [3:0] MODE_ROW2D = 4'b0100;
  localparam logic [3:0] MODE_CLN2D = 4'b1000;

  typedef logic [VLSU_ADDR_BITS-1:0] addr_t;
  typedef logic [VLEN_BITS-1:0]      cnt_t;
  typedef logic [VLEN_BITS:0]        nbs_t;   // one extra bit for shifts/sums
  typedef logic [TXN_NBS_W-1:0]      tnbs_t;  // 1..TXN_NBS
  typedef logic [OFF_W-1:0]          off_t;

  typedef struct packed {
    logic [3:0] mode;
    logic [1:0] sew;
    cnt_t       nr_elem;
    cnt_t       nr_seg;
    addr_t      seg_stride;
    addr_t      grp_stride;
    cnt_t       rmn_grp;
    cnt_t       rmn_seg;
    addr_t      grp_base;
    addr_t      seg_addr;
  } meta_glb_t;

  // nbs keeps only the low bits: it is only emitted for single-txn
  // segments, where it never exceeds TXN_NBS.
  typedef struct packed {
    tnbs_t nbs;
    off_t  page_off;
    cnt_t  txn_num;
    cnt_t  txn_cnt;
    tnbs_t lt_n;
  } meta_seglv_t;

  function automatic logic is_incr(input logic [3:0] m);
    return (m & MODE_INCR) != '0;
  endfunction

  function automatic logic is_strd(input logic [3:0] m);
    return (m & MODE_STRD) != '0;
  endfunction

  function automatic logic is_row2d(input logic [3:0] m);
    return (m & MODE_ROW2D) != '0;
  endfunction

  function automatic logic is_cln2d(input logic [3:0] m);
    return (m & MODE_CLN2D) != '0;
  endfunction

  function automatic logic is_last_txn(input meta_seglv_t s);
    return s.txn_cnt == s.txn_num;
  endfunction

  function automatic logic is_final_txn(input meta_glb_t g, input meta_seglv_t s);
    return is_last_txn(s) && (g.rmn_seg == '0) && (g.rmn_grp == '0);
  endfunction

  // Segment-level metadata for the segment starting at g.seg_addr.
  function automatic meta_seglv_t seglv_init(input meta_glb_t g);
    meta_seglv_t s;
    nbs_t        elem_nbs;
    nbs_t        nbs;
    nbs_t        tot;
    elem_nbs = nbs_t'(g.nr_elem) << g.sew;
    // Column-2D: every group but the last moves whole slots; the last one
    // carries the remainder, unless the row is an exact slot multiple.
    if (is_cln2d(g.mode))
      nbs = (g.rmn_grp == '0 && elem_nbs[OFF_W-1:0] != '0) ?
            nbs_t'(elem_nbs[OFF_W-1:0]) : nbs_t'(TXN_NBS);
    else if (is_incr(g.mode))
      nbs = elem_nbs;
    else if (is_strd(g.mode))
      nbs = nbs_t'(1) << g.sew;
    else if (is_row2d(g.mode))
      nbs = nbs_t'(NR_LANES) << g.sew;
    else
      nbs = nbs_t'(TXN_NBS);
    tot        = nbs_t'(g.seg_addr[OFF_W-1:0]) + nbs;
    s.nbs      = tnbs_t'(nbs);
    s.page_off = g.seg_addr[OFF_W-1:0];
    s.txn_num  = cnt_t'((tot - nbs_t'(1)) >> OFF_W);
    s.txn_cnt  = '0;
    s.lt_n     = (tot[OFF_W-1:0] != '0) ? tnbs_t'(tot[OFF_W-1:0]) : tnbs_t'(TXN_NBS);
    return s;
  endfunction

endpackage

// File: rtl/vlsu_txn_addr_gen.sv
// Combinational address/length of the current transaction of a segment.
//   seg_addr_i : segment base address (nibbles)
//   seglv_i    : segment-level metadata incl. current txnCnt
//   addr_o     : transaction start address
//   nbs_o      : valid nibbles in this transaction (1..TXN_NBS)
//   last_o     : this is the last transaction of the segment
module vlsu_txn_addr_gen
  import vlsu_txn_sequencer_pkg::*;
(
  input  logic [VLSU_ADDR_BITS-1:0] seg_addr_i,
  input  meta_seglv_t               seglv_i,
  output logic [VLSU_ADDR_BITS-1:0] addr_o,
  output logic [TXN_NBS_W-1:0]      nbs_o,
  output logic                      last_o
);

  always_comb begin
    last_o = is_last_txn(seglv_i);
    // Later txns start on slot boundaries; wraps modulo the address width.
    if (seglv_i.txn_cnt == '0)
      addr_o = seg_addr_i;
    else
      addr_o = {seg_addr_i[VLSU_ADDR_BITS-1:OFF_W], {OFF_W{1'b0}}}
             + (VLSU_ADDR_BITS'(seglv_i.txn_cnt) << OFF_W);
    if (seglv_i.txn_num == '0)
      nbs_o = seglv_i.nbs;
    else if (seglv_i.txn_cnt == '0)
      nbs_o = tnbs_t'(TXN_NBS) - tnbs_t'(seglv_i.page_off);
    else if (last_o)
      nbs_o = seglv_i.lt_n;
    else
      nbs_o = tnbs_t'(TXN_NBS);
  end

endmodule

// File: rtl/vlsu_txn_sequencer.sv
// Sequences one VLSU request into bus transactions: groups, then segments,
// then slot-sized transactions. One SEG_INIT bubble per segment, txns of a
// segment issue back-to-back.
//   clk_i, rst_ni                : clock, async active-low reset
//   req_*_i / req_ready_o        : request from the VLSU request queue
//   txn_valid_o / txn_ready_i    : transaction handshake to the bus queue
//   txn_addr_o, txn_nbs_o        : transaction start address and length
//   txn_last_seg_o, txn_final_o  : last txn of segment / of request
//   busy_o                       : a request is in flight
module vlsu_txn_sequencer
  import vlsu_txn_sequencer_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [VLSU_ADDR_BITS-1:0] req_addr_i,
  input  logic [3:0]                req_mode_i,
  input  logic [1:0]                req_sew_i,
  input  logic [VLEN_BITS-1:0]      req_nr_elem_i,
  input  logic [VLEN_BITS-1:0]      req_nr_seg_i,
  input  logic [VLEN_BITS-1:0]      req_nr_grp_i,
  input  logic [VLSU_ADDR_BITS-1:0] req_seg_stride_i,
  input  logic [VLSU_ADDR_BITS-1:0] req_grp_stride_i,
  output logic                      txn_valid_o,
  input  logic                      txn_ready_i,
  output logic [VLSU_ADDR_BITS-1:0] txn_addr_o,
  output logic [TXN_NBS_W-1:0]      txn_nbs_o,
  output logic                      txn_last_seg_o,
  output logic                      txn_final_o,
  output logic                      busy_o
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SEG_INIT = 2'd1;
  localparam logic [1:0] ST_ISSUE    = 2'd2;

  logic [1:0]  state_q, state_d;
  meta_glb_t   glb_q, glb_d;
  meta_seglv_t seglv_q, seglv_d;

  logic [VLSU_ADDR_BITS-1:0] gen_addr;
  logic [TXN_NBS_W-1:0]      gen_nbs;
  logic                      gen_last;
  logic                      issue;

  vlsu_txn_addr_gen u_addr_gen (
    .seg_addr_i (glb_q.seg_addr),
    .seglv_i    (seglv_q),
    .addr_o     (gen_addr),
    .nbs_o      (gen_nbs),
    .last_o     (gen_last)
  );

  always_comb begin
    state_d = state_q;
    glb_d   = glb_q;
    seglv_d = seglv_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          glb_d.mode       = req_mode_i;
          glb_d.sew        = req_sew_i;
          glb_d.nr_elem    = req_nr_elem_i;
          glb_d.nr_seg     = req_nr_seg_i;
          glb_d.seg_stride = req_seg_stride_i;
          glb_d.grp_stride = req_grp_stride_i;
          glb_d.rmn_grp    = req_nr_grp_i - cnt_t'(1);
          glb_d.rmn_seg    = req_nr_seg_i - cnt_t'(1);
          glb_d.grp_base   = req_addr_i;
          glb_d.seg_addr   = req_addr_i;
          state_d          = ST_SEG_INIT;
        end
      end
      ST_SEG_INIT: begin
        seglv_d = seglv_init(glb_q);
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (txn_ready_i) begin
          if (!is_last_txn(seglv_q)) begin
            seglv_d.txn_cnt = seglv_q.txn_cnt + cnt_t'(1);
          end else if (is_final_txn(glb_q, seglv_q)) begin
            state_d = ST_IDLE;
          end else if (glb_q.rmn_seg != '0) begin
            glb_d.rmn_seg  = glb_q.rmn_seg - cnt_t'(1);
            glb_d.seg_addr = glb_q.seg_addr + glb_q.seg_stride;
            state_d        = ST_SEG_INIT;
          end else begin
            // Next group restarts its segment walk from the new group base.
            glb_d.rmn_grp  = glb_q.rmn_grp - cnt_t'(1);
            glb_d.rmn_seg  = glb_q.nr_seg - cnt_t'(1);
            glb_d.grp_base = glb_q.grp_base + glb_q.grp_stride;
            glb_d.seg_addr = glb_q.grp_base + glb_q.grp_stride;
            state_d        = ST_SEG_INIT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      glb_q   <= '0;
      seglv_q <= '0;
    end else begin
      state_q <= state_d;
      glb_q   <= glb_d;
      seglv_q <= seglv_d;
    end
  end

  // All txn outputs are qualified by ISSUE so idle/reset values are zero.
  assign issue          = (state_q == ST_ISSUE);
  assign req_ready_o    = (state_q == ST_IDLE);
  assign busy_o         = (state_q != ST_IDLE);
  assign txn_valid_o    = issue;
  assign txn_addr_o     = issue ? gen_addr : '0;
  assign txn_nbs_o      = issue ? gen_nbs : '0;
  assign txn_last_seg_o = issue & gen_last;
  assign txn_final_o    = issue & is_final_txn(glb_q, seglv_q);

endmodule

// File: tb/tb_vlsu_txn_sequencer.sv
module tb_vlsu_txn_sequencer;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  mode;
    logic [1:0]  sew;
    logic [15:0] nr_elem;
    logic [15:0] nr_seg;
    logic [15:0] nr_grp;
    logic [31:0] seg_stride;
    logic [31:0] grp_stride;
  } req_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [6:0]  nbs;
    logic        last;
    logic        fin;
  } exp_t;

  typedef struct {
    req_t             req;
    int               n;
    logic [7:0][31:0] ea;
    logic [7:0][6:0]  en;
    logic [7:0]       el;
    int               stall_at;
    int               stall_len;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_mode;
  logic [1:0]  req_sew;
  logic [15:0] req_nr_elem, req_nr_seg, req_nr_grp;
  logic [31:0] req_seg_stride, req_grp_stride;
  logic        txn_valid, txn_ready;
  logic [31:0] txn_addr;
  logic [6:0]  txn_nbs;
  logic        txn_last_seg, txn_final, busy;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  vec_t tbl[7];

  always #5 clk = ~clk;

  vlsu_txn_sequencer dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_addr_i       (req_addr),
    .req_mode_i       (req_mode),
    .req_sew_i        (req_sew),
    .req_nr_elem_i    (req_nr_elem),
    .req_nr_seg_i     (req_nr_seg),
    .req_nr_grp_i     (req_nr_grp),
    .req_seg_stride_i (req_seg_stride),
    .req_grp_stride_i (req_grp_stride),
    .txn_valid_o      (txn_valid),
    .txn_ready_i      (txn_ready),
    .txn_addr_o       (txn_addr),
    .txn_nbs_o        (txn_nbs),
    .txn_last_seg_o   (txn_last_seg),
    .txn_final_o      (txn_final),
    .busy_o           (busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; req_valid = 1'b0; txn_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_ni = 1'b1;
    step();
  endtask

  function automatic req_t mkreq(input logic [31:0] a, input logic [3:0] m, input logic [1:0] s,
                                 input int ne, input int ns, input int ng,
                                 input logic [31:0] ss, input logic [31:0] gs);
    req_t r;
    r.addr = a; r.mode = m; r.sew = s;
    r.nr_elem = 16'(ne); r.nr_seg = 16'(ns); r.nr_grp = 16'(ng);
    r.seg_stride = ss; r.grp_stride = gs;
    return r;
  endfunction

  // Reference: each segment is the nibble range [base, base+nbs), cut at
  // every 64-nibble slot boundary.
  task automatic model(input req_t r);
    logic [31:0] base, cur;
    int elem, nbs, rem, room, chunk;
    exp_t e;
    exp_q.delete();
    elem = int'(r.nr_elem) << r.sew;
    for (int g = 0; g < int'(r.nr_grp); g++) begin
      for (int s = 0; s < int'(r.nr_seg); s++) begin
        base = r.addr + 32'(g) * r.grp_stride + 32'(s) * r.seg_stride;
        case (r.mode)
          4'b0001: nbs = elem;
          4'b0010: nbs = 1 << r.sew;
          4'b0100: nbs = 4 << r.sew;
          default: nbs = (g == int'(r.nr_grp) - 1 && elem % 64 != 0) ? elem % 64 : 64;
        endcase
        cur = base; rem = nbs;
        while (rem > 0) begin
          room  = 64 - int'(cur[5:0]);
          chunk = (rem < room) ? rem : room;
          e.addr = cur;
          e.nbs  = 7'(chunk);
          e.last = (chunk == rem);
          e.fin  = (chunk == rem) && (s == int'(r.nr_seg) - 1) && (g == int'(r.nr_grp) - 1);
          exp_q.push_back(e);
          cur = cur + 32'(chunk);
          rem = rem - chunk;
        end
      end
    end
  endtask

  task automatic run_case(input string tag, input req_t r, input int stall_at,
                          input int stall_len, input bit rnd);
    int   k, gap, held;
    bit   first, rdy;
    exp_t e;
    k = 0; gap = 0; held = 0; first = 1'b1;
    check({tag, " idle_ready"}, 64'(req_ready), 64'(1));
    req_addr = r.addr; req_mode = r.mode; req_sew = r.sew;
    req_nr_elem = r.nr_elem; req_nr_seg = r.nr_seg; req_nr_grp = r.nr_grp;
    req_seg_stride = r.seg_stride; req_grp_stride = r.grp_stride;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check({tag, " busy"}, 64'(busy), 64'(1));
    check({tag, " req_ready_busy"}, 64'(req_ready), 64'(0));
    while (k < exp_q.size()) begin
      if (txn_valid) begin
        e = exp_q[k];
        if (first) begin
          if (k == 0 || exp_q[k-1].last)
            check($sformatf("%s t%0d gap", tag, k), 64'(gap), 64'(1));
          else
            check($sformatf("%s t%0d gap", tag, k), 64'(gap), 64'(0));
        end
        check($sformatf("%s t%0d addr", tag, k), 64'(txn_addr), 64'(e.addr));
        check($sformatf("%s t%0d nbs", tag, k), 64'(txn_nbs), 64'(e.nbs));
        check($sformatf("%s t%0d last", tag, k), 64'(txn_last_seg), 64'(e.last));
        check($sformatf("%s t%0d final", tag, k), 64'(txn_final), 64'(e.fin));
        if (k == stall_at && held < stall_len) begin
          rdy = 1'b0; held++;
        end else if (rnd) rdy = ($urandom_range(0, 3) != 0);
        else rdy = 1'b1;
        txn_ready = rdy;
        step();
        if (rdy) begin k++; gap = 0; first = 1'b1; end
        else first = 1'b0;
      end else begin
        txn_ready = 1'b0;
        if (gap > 50) begin
          check($sformatf("%s t%0d timeout", tag, k), 64'(gap), 64'(0));
          do_reset();
          return;
        end
        gap++;
        step();
      end
    end
    txn_ready = 1'b0;
    check({tag, " end_valid"}, 64'(txn_valid), 64'(0));
    check({tag, " end_busy"}, 64'(busy), 64'(0));
    check({tag, " end_ready"}, 64'(req_ready), 64'(1));
  endtask

  task automatic load_tbl(input int i);
    exp_t e;
    exp_q.delete();
    for (int j = 0; j < tbl[i].n; j++) begin
      e.addr = tbl[i].ea[j]; e.nbs = tbl[i].en[j]; e.last = tbl[i].el[j];
      e.fin  = (j == tbl[i].n - 1);
      exp_q.push_back(e);
    end
  endtask

  initial begin
    req_t r;
    rst_ni = 1'b1; req_valid = 1'b0; txn_ready = 1'b0;
    req_addr = '0; req_mode = '0; req_sew = '0; req_nr_elem = '0;
    req_nr_seg = '0; req_nr_grp = '0; req_seg_stride = '0; req_grp_stride = '0;

    for (int i = 0; i < 7; i++) begin
      tbl[i].ea = '0; tbl[i].en = '0; tbl[i].el = '0;
      tbl[i].stall_at = -1; tbl[i].stall_len = 0;
    end
    // incr, stalled 5 cycles on the 2nd txn
    tbl[0].req = mkreq(32'h10, 4'b0001, 2'd1, 100, 1, 1, 32'h0, 32'h0);
    tbl[0].n = 4; tbl[0].el = 8'b1000; tbl[0].stall_at = 1; tbl[0].stall_len = 5;
    tbl[0].ea[0] = 32'h10; tbl[0].ea[1] = 32'h40; tbl[0].ea[2] = 32'h80; tbl[0].ea[3] = 32'hC0;
    tbl[0].en[0] = 7'd48;  tbl[0].en[1] = 7'd64;  tbl[0].en[2] = 7'd64;  tbl[0].en[3] = 7'd24;
    // strided, three segments
    tbl[1].req = mkreq(32'h3E, 4'b0010, 2'd2, 1, 3, 1, 32'h100, 32'h0);
    tbl[1].n = 6; tbl[1].el = 8'b101010;
    tbl[1].ea[0] = 32'h3E;  tbl[1].ea[1] = 32'h40;  tbl[1].ea[2] = 32'h13E;
    tbl[1].ea[3] = 32'h140; tbl[1].ea[4] = 32'h23E; tbl[1].ea[5] = 32'h240;
    for (int j = 0; j < 6; j++) tbl[1].en[j] = 7'd2;
    // column-2D, remainder only in the last group
    tbl[2].req = mkreq(32'h0, 4'b1000, 2'd1, 40, 2, 2, 32'h1000, 32'h40);
    tbl[2].n = 4; tbl[2].el = 8'b1111;
    tbl[2].ea[0] = 32'h0;  tbl[2].ea[1] = 32'h1000; tbl[2].ea[2] = 32'h40; tbl[2].ea[3] = 32'h1040;
    tbl[2].en[0] = 7'd64;  tbl[2].en[1] = 7'd64;    tbl[2].en[2] = 7'd16;  tbl[2].en[3] = 7'd16;
    // address wrap
    tbl[3].req = mkreq(32'hFFFF_FFF0, 4'b0001, 2'd0, 32, 1, 1, 32'h0, 32'h0);
    tbl[3].n = 2; tbl[3].el = 8'b10;
    tbl[3].ea[0] = 32'hFFFF_FFF0; tbl[3].ea[1] = 32'h0;
    tbl[3].en[0] = 7'd16;         tbl[3].en[1] = 7'd16;
    // row-2D, 32 nibbles straddling a slot boundary
    tbl[4].req = mkreq(32'h7C, 4'b0100, 2'd3, 1, 1, 1, 32'h0, 32'h0);
    tbl[4].n = 2; tbl[4].el = 8'b10;
    tbl[4].ea[0] = 32'h7C; tbl[4].ea[1] = 32'h80;
    tbl[4].en[0] = 7'd4;   tbl[4].en[1] = 7'd28;
    // exactly one aligned full slot
    tbl[5].req = mkreq(32'h100, 4'b0001, 2'd0, 64, 1, 1, 32'h0, 32'h0);
    tbl[5].n = 1; tbl[5].el = 8'b1; tbl[5].ea[0] = 32'h100; tbl[5].en[0] = 7'd64;
    // column-2D row that is an exact slot multiple: full 64 even in last group
    tbl[6].req = mkreq(32'h20, 4'b1000, 2'd1, 32, 1, 1, 32'h0, 32'h0);
    tbl[6].n = 2; tbl[6].el = 8'b10;
    tbl[6].ea[0] = 32'h20; tbl[6].ea[1] = 32'h40;
    tbl[6].en[0] = 7'd32;  tbl[6].en[1] = 7'd32;

    #1 rst_ni = 1'b0;
    #2;
    check("rst req_ready", 64'(req_ready), 64'(1));
    check("rst txn_valid", 64'(txn_valid), 64'(0));
    check("rst txn_addr", 64'(txn_addr), 64'(0));
    check("rst txn_nbs", 64'(txn_nbs), 64'(0));
    check("rst last_seg", 64'(txn_last_seg), 64'(0));
    check("rst final", 64'(txn_final), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    @(negedge clk) rst_ni = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      load_tbl(i);
      run_case($sformatf("vec%0d", i), tbl[i].req, tbl[i].stall_at, tbl[i].stall_len, 1'b0);
    end

    // Reset while the 2nd txn of the incr case is on the bus.
    r = tbl[0].req;
    req_addr = r.addr; req_mode = r.mode; req_sew = r.sew; req_nr_elem = r.nr_elem;
    req_nr_seg = r.nr_seg; req_nr_grp = r.nr_grp;
    req_seg_stride = r.seg_stride; req_grp_stride = r.grp_stride;
    req_valid = 1'b1; step(); req_valid = 1'b0;
    step();
    check("mid first_valid", 64'(txn_valid), 64'(1));
    txn_ready = 1'b1; step(); txn_ready = 1'b0;
    check("mid 2nd addr", 64'(txn_addr), 64'(32'h40));
    #2 rst_ni = 1'b0;
    #1;
    check("mid rst valid", 64'(txn_valid), 64'(0));
    check("mid rst req_ready", 64'(req_ready), 64'(1));
    check("mid rst busy", 64'(busy), 64'(0));
    @(negedge clk) rst_ni = 1'b1;
    step();
    load_tbl(0);
    run_case("after_rst", tbl[0].req, -1, 0, 1'b0);

    // Randomized requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      r.addr       = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : $urandom;
      r.mode       = 4'b0001 << $urandom_range(0, 3);
      r.sew        = 2'($urandom_range(0, 3));
      r.nr_elem    = 16'($urandom_range(1, 200));
      r.nr_seg     = 16'($urandom_range(1, 3));
      r.nr_grp     = 16'($urandom_range(1, 3));
      r.seg_stride = $urandom;
      r.grp_stride = $urandom;
      model(r);
      run_case($sformatf("rnd%0d", i), r, -1, 0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
